// File: rtl/frog_motion_ctrl.sv
// Frog movement controller: grid stepping with hold-to-repeat, lives counter,
// timed respawn window and game-over handling. All outputs are registered.
module frog_motion_ctrl #(
    parameter int TILE_SIZE      = 32,
    parameter int GRID_W         = 20,
    parameter int GRID_H         = 15,
    parameter int START_COL      = 10,
    parameter int START_ROW      = 12,
    parameter int X_W            = 10,
    parameter int Y_W            = 9,
    parameter int SCORE_W        = 4,
    parameter int SCORE_INI      = 1,
    parameter int LIVES_INI      = 3,
    parameter int REPEAT_DELAY   = 3125000,
    parameter int REPEAT_PERIOD  = 1562500,
    parameter int RESPAWN_CYCLES = 25000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Frog_Up,
    input  logic               i_Frog_Dn,
    input  logic               i_Frog_Lt,
    input  logic               i_Frog_Rt,
    input  logic               i_Has_Collided,
    input  logic               i_Game_Active,
    output logic [X_W-1:0]     o_Frog_X,
    output logic [Y_W-1:0]     o_Frog_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [3:0]         o_Lives,
    output logic               o_Level_Up,
    output logic               o_Move,
    output logic               o_Respawning,
    output logic               o_Game_Over
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PLAY      = 2'd1;
    localparam logic [1:0] RESPAWN   = 2'd2;
    localparam logic [1:0] GAME_OVER = 2'd3;

    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_DN = 2'd1;
    localparam logic [1:0] DIR_LT = 2'd2;
    localparam logic [1:0] DIR_RT = 2'd3;

    localparam int COL_W    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROW_W    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;
    localparam int RSP_LAST = (RESPAWN_CYCLES > 1) ? RESPAWN_CYCLES - 1 : 0;
    localparam int RSP_W    = (RSP_LAST > 0) ? $clog2(RSP_LAST + 1) : 1;

    localparam logic [COL_W-1:0]   SPAWN_COL   = COL_W'(START_COL);
    localparam logic [ROW_W-1:0]   SPAWN_ROW   = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0]   LAST_COL    = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(GRID_H - 1);
    localparam logic [HOLD_W-1:0]  DELAY_CNT   = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0]  PERIOD_CNT  = HOLD_W'(REPEAT_PERIOD);
    localparam logic [RSP_W-1:0]   RSP_END     = RSP_W'(RSP_LAST);
    localparam logic [SCORE_W-1:0] SCORE_START = SCORE_W'(SCORE_INI);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [3:0]         LIVES_START = 4'(LIVES_INI);
    localparam logic [X_W-1:0]     SPAWN_X     = X_W'(START_COL * TILE_SIZE);
    localparam logic [Y_W-1:0]     SPAWN_Y     = Y_W'(START_ROW * TILE_SIZE);

    logic [1:0]         state, state_n;
    logic [COL_W-1:0]   col, col_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [SCORE_W-1:0] score_n;
    logic [3:0]         lives_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n, hold_inc;
    logic               repeating, repeating_n;
    logic               last_valid, last_valid_n;
    logic [1:0]         last_dir, last_dir_n;
    logic [RSP_W-1:0]   rsp_cnt, rsp_n;
    logic               move_n, level_up_n;
    logic               attempt, go_spawn, clear_track;
    logic               dir_valid;
    logic [1:0]         dir;
    logic [X_W-1:0]     x_n;
    logic [Y_W-1:0]     y_n;

    // Only a single pressed direction counts as a request.
    always_comb begin
        dir_valid = 1'b0;
        dir       = DIR_UP;
        case ({i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt})
            4'b1000: begin dir_valid = 1'b1; dir = DIR_UP; end
            4'b0100: begin dir_valid = 1'b1; dir = DIR_DN; end
            4'b0010: begin dir_valid = 1'b1; dir = DIR_LT; end
            4'b0001: begin dir_valid = 1'b1; dir = DIR_RT; end
            default: begin dir_valid = 1'b0; dir = DIR_UP; end
        endcase
    end

    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        score_n      = o_Score;
        lives_n      = o_Lives;
        hold_n       = hold_cnt;
        repeating_n  = repeating;
        last_valid_n = last_valid;
        last_dir_n   = last_dir;
        rsp_n        = rsp_cnt;
        move_n       = 1'b0;
        level_up_n   = 1'b0;
        attempt      = 1'b0;
        go_spawn     = 1'b0;
        clear_track  = 1'b0;
        hold_inc     = hold_cnt + HOLD_W'(1);

        if (!i_Game_Active) begin
            state_n     = IDLE;
            score_n     = SCORE_START;
            lives_n     = LIVES_START;
            rsp_n       = '0;
            go_spawn    = 1'b1;
            clear_track = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_n     = PLAY;
                    score_n     = SCORE_START;
                    lives_n     = LIVES_START;
                    rsp_n       = '0;
                    go_spawn    = 1'b1;
                    clear_track = 1'b1;
                end
                PLAY: begin
                    if (i_Has_Collided) begin
                        lives_n     = o_Lives - 4'd1;
                        go_spawn    = 1'b1;
                        clear_track = 1'b1;
                        rsp_n       = '0;
                        state_n     = (o_Lives == 4'd1) ? GAME_OVER : RESPAWN;
                    end else if (!dir_valid) begin
                        clear_track = 1'b1;
                    end else begin
                        last_valid_n = 1'b1;
                        last_dir_n   = dir;
                        if (!last_valid || (dir != last_dir)) begin
                            attempt     = 1'b1;
                            hold_n      = '0;
                            repeating_n = 1'b0;
                        end else if (REPEAT_DELAY != 0) begin
                            // Blocked steps still restart the timer, so repeat cadence is position-independent.
                            if (!repeating && (hold_inc == DELAY_CNT)) begin
                                attempt     = 1'b1;
                                hold_n      = '0;
                                repeating_n = 1'b1;
                            end else if (repeating && (hold_inc == PERIOD_CNT)) begin
                                attempt = 1'b1;
                                hold_n  = '0;
                            end else begin
                                hold_n = hold_inc;
                            end
                        end

                        if (attempt) begin
                            case (dir)
                                DIR_UP: begin
                                    if (row == '0) begin
                                        go_spawn    = 1'b1;
                                        clear_track = 1'b1;
                                        move_n      = 1'b1;
                                        level_up_n  = 1'b1;
                                        if (o_Score != SCORE_MAX)
                                            score_n = o_Score + SCORE_W'(1);
                                    end else begin
                                        row_n  = row - ROW_W'(1);
                                        move_n = 1'b1;
                                    end
                                end
                                DIR_DN: begin
                                    if (row != LAST_ROW) begin
                                        row_n  = row + ROW_W'(1);
                                        move_n = 1'b1;
                                    end
                                end
                                DIR_LT: begin
                                    if (col != '0) begin
                                        col_n  = col - COL_W'(1);
                                        move_n = 1'b1;
                                    end
                                end
                                default: begin
                                    if (col != LAST_COL) begin
                                        col_n  = col + COL_W'(1);
                                        move_n = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                RESPAWN: begin
                    go_spawn    = 1'b1;
                    clear_track = 1'b1;
                    if (rsp_cnt == RSP_END) begin
                        state_n = PLAY;
                        rsp_n   = '0;
                    end else begin
                        rsp_n = rsp_cnt + RSP_W'(1);
                    end
                end
                default: begin
                    go_spawn    = 1'b1;
                    clear_track = 1'b1;
                end
            endcase
        end

        if (go_spawn) begin
            col_n = SPAWN_COL;
            row_n = SPAWN_ROW;
        end
        if (clear_track) begin
            last_valid_n = 1'b0;
            hold_n       = '0;
            repeating_n  = 1'b0;
        end
    end

    // Pixel coordinates are computed from the next tile so they land on the same edge as the step.
    assign x_n = X_W'(col_n) * X_W'(TILE_SIZE);
    assign y_n = Y_W'(row_n) * Y_W'(TILE_SIZE);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= IDLE;
            col          <= SPAWN_COL;
            row          <= SPAWN_ROW;
            hold_cnt     <= '0;
            repeating    <= 1'b0;
            last_valid   <= 1'b0;
            last_dir     <= DIR_UP;
            rsp_cnt      <= '0;
            o_Frog_X     <= SPAWN_X;
            o_Frog_Y     <= SPAWN_Y;
            o_Score      <= SCORE_START;
            o_Lives      <= LIVES_START;
            o_Level_Up   <= 1'b0;
            o_Move       <= 1'b0;
            o_Respawning <= 1'b0;
            o_Game_Over  <= 1'b0;
        end else begin
            state        <= state_n;
            col          <= col_n;
            row          <= row_n;
            hold_cnt     <= hold_n;
            repeating    <= repeating_n;
            last_valid   <= last_valid_n;
            last_dir     <= last_dir_n;
            rsp_cnt      <= rsp_n;
            o_Frog_X     <= x_n;
            o_Frog_Y     <= y_n;
            o_Score      <= score_n;
            o_Lives      <= lives_n;
            o_Level_Up   <= level_up_n;
            o_Move       <= move_n;
            o_Respawning <= (state_n == RESPAWN);
            o_Game_Over  <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed, table-driven bench for frog_motion_ctrl using short repeat and respawn timings.
module tb_frog_motion_ctrl;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] UP   = 4'b1000;
    localparam logic [3:0] DN   = 4'b0100;
    localparam logic [3:0] LT   = 4'b0010;
    localparam logic [3:0] RT   = 4'b0001;

    logic       clk = 1'b0;
    logic       rst, act, up, dn, lt, rt, coll;
    logic [9:0] frog_x;
    logic [8:0] frog_y;
    logic [3:0] score, lives;
    logic       level_up, move, respawning, game_over;

    typedef struct {
        logic       rst;
        logic       act;
        logic [3:0] dir;
        logic       coll;
        int         ex;
        int         ey;
        int         escore;
        int         elives;
        logic       emove;
        logic       elvl;
        logic       eresp;
        logic       ego;
    } vec_t;

    vec_t vecs[160];
    int   numVecs    = 0;
    int   passCount  = 0;
    int   checkCount = 0;

    frog_motion_ctrl #(
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2),
        .RESPAWN_CYCLES(3)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Frog_Up     (up),
        .i_Frog_Dn     (dn),
        .i_Frog_Lt     (lt),
        .i_Frog_Rt     (rt),
        .i_Has_Collided(coll),
        .i_Game_Active (act),
        .o_Frog_X      (frog_x),
        .o_Frog_Y      (frog_y),
        .o_Score       (score),
        .o_Lives       (lives),
        .o_Level_Up    (level_up),
        .o_Move        (move),
        .o_Respawning  (respawning),
        .o_Game_Over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic a, input logic [3:0] d, input logic c,
                          input int ex, input int ey, input int es, input int el,
                          input logic em, input logic elv, input logic er, input logic eg);
        vecs[numVecs].rst    = r;
        vecs[numVecs].act    = a;
        vecs[numVecs].dir    = d;
        vecs[numVecs].coll   = c;
        vecs[numVecs].ex     = ex;
        vecs[numVecs].ey     = ey;
        vecs[numVecs].escore = es;
        vecs[numVecs].elives = el;
        vecs[numVecs].emove  = em;
        vecs[numVecs].elvl   = elv;
        vecs[numVecs].eresp  = er;
        vecs[numVecs].ego    = eg;
        numVecs++;
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic [3:0] d, input logic c);
        rst  = r;
        act  = a;
        {up, dn, lt, rt} = d;
        coll = c;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [30:0] got, exp;
        got = {frog_x, frog_y, score, lives, move, level_up, respawning, game_over};
        exp = {10'(v.ex), 9'(v.ey), 4'(v.escore), 4'(v.elives), v.emove, v.elvl, v.eresp, v.ego};
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL vec%0d: got x=%0d y=%0d score=%0d lives=%0d move=%b lvl=%b resp=%b go=%b, expected x=%0d y=%0d score=%0d lives=%0d move=%b lvl=%b resp=%b go=%b",
                      idx, frog_x, frog_y, score, lives, move, level_up, respawning, game_over,
                      v.ex, v.ey, v.escore, v.elives, v.emove, v.elvl, v.eresp, v.ego);
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checkCount++;
        if (got == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int moveCount;
        int highCycles;
        bit dropped;

        // reset, enter PLAY, single right step
        addVec(1, 0, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, RT,   0, 352, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, NONE, 0, 352, 384, 1, 3, 0, 0, 0, 0);
        // hold left 10 cycles: steps on cycles 0, 4, 6, 8
        addVec(0, 1, LT, 0, 320, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, LT, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT, 0, 288, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, LT, 0, 288, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT, 0, 256, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, LT, 0, 256, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT, 0, 224, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, LT, 0, 224, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, UP | LT, 0, 224, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE,    0, 224, 384, 1, 3, 0, 0, 0, 0);
        // twelve up presses to row 0, then the goal step
        for (int k = 1; k <= 12; k++) begin
            addVec(0, 1, UP,   0, 224, 384 - 32 * k, 1, 3, 1, 0, 0, 0);
            addVec(0, 1, NONE, 0, 224, 384 - 32 * k, 1, 3, 0, 0, 0, 0);
        end
        addVec(0, 1, UP,   0, 320, 384, 2, 3, 1, 1, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 2, 3, 0, 0, 0, 0);
        // collision, right held through respawn
        addVec(0, 1, NONE, 1, 320, 384, 2, 2, 0, 0, 1, 0);
        addVec(0, 1, RT,   0, 320, 384, 2, 2, 0, 0, 1, 0);
        addVec(0, 1, RT,   0, 320, 384, 2, 2, 0, 0, 1, 0);
        addVec(0, 1, RT,   0, 320, 384, 2, 2, 0, 0, 0, 0);
        addVec(0, 1, RT,   0, 352, 384, 2, 2, 1, 0, 0, 0);
        addVec(0, 1, NONE, 0, 352, 384, 2, 2, 0, 0, 0, 0);
        // collision wins over a same-cycle down request
        addVec(0, 1, DN,   1, 320, 384, 2, 1, 0, 0, 1, 0);
        addVec(0, 1, NONE, 0, 320, 384, 2, 1, 0, 0, 1, 0);
        addVec(0, 1, NONE, 0, 320, 384, 2, 1, 0, 0, 1, 0);
        addVec(0, 1, NONE, 0, 320, 384, 2, 1, 0, 0, 0, 0);
        // last life lost, game over ignores inputs, then back to IDLE
        addVec(0, 1, NONE, 1, 320, 384, 2, 0, 0, 0, 0, 1);
        addVec(0, 1, RT,   0, 320, 384, 2, 0, 0, 0, 0, 1);
        addVec(0, 1, NONE, 1, 320, 384, 2, 0, 0, 0, 0, 1);
        addVec(0, 0, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        // hold down into the bottom row; blocked repeats give no move
        addVec(0, 1, DN, 0, 320, 416, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 416, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 416, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 416, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 448, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 448, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 448, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 448, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, DN, 0, 320, 448, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 448, 1, 3, 0, 0, 0, 0);
        // reset during respawn
        addVec(0, 1, NONE, 1, 320, 384, 1, 2, 0, 0, 1, 0);
        addVec(1, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        // reset during a held repeat
        addVec(0, 1, LT,   0, 288, 384, 1, 3, 1, 0, 0, 0);
        addVec(0, 1, LT,   0, 288, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, LT,   0, 288, 384, 1, 3, 0, 0, 0, 0);
        addVec(1, 1, LT,   0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);
        addVec(0, 1, NONE, 0, 320, 384, 1, 3, 0, 0, 0, 0);

        applyStimulus(1, 0, NONE, 0);
        stepCycle();
        for (int i = 0; i < numVecs; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].act, vecs[i].dir, vecs[i].coll);
            stepCycle();
            checkOutput(i, vecs[i]);
        end

        // long left hold from col 10: 14 attempts in 30 cycles, only 10 land
        moveCount = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(0, 1, LT, 0);
            stepCycle();
            if (move) moveCount++;
        end
        applyStimulus(0, 1, NONE, 0);
        stepCycle();
        checkVal("left_edge_moves", moveCount, 10);
        checkVal("left_edge_x", int'(frog_x), 0);

        // respawn window length, bounded wait
        applyStimulus(0, 1, NONE, 1);
        stepCycle();
        applyStimulus(0, 1, NONE, 0);
        checkVal("respawn_lives", int'(lives), 2);
        checkVal("respawn_x", int'(frog_x), 320);
        highCycles = respawning ? 1 : 0;
        dropped = 1'b0;
        for (int c = 0; c < 10 && !dropped; c++) begin
            stepCycle();
            if (respawning) highCycles++;
            else dropped = 1'b1;
        end
        checkVal("respawn_dropped", int'(dropped), 1);
        checkVal("respawn_cycles", highCycles, 3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/frog_motion_ctrl.md
Name: frog_motion_ctrl

Overview:
Parametrised successor to the single-frog movement controller. It moves the player on a configurable tile grid and adds hold-to-repeat movement, a lives counter, a timed respawn/invulnerability window and a game-over state. It sits between the switch debouncers and the collision/render blocks. It drives frog pixel position, score, lives and status flags.

Parameters:
TILE_SIZE, 32, tile edge in pixels
GRID_W, 20, grid columns (col 0..GRID_W-1)
GRID_H, 15, grid rows (row 0 = goal row)
START_COL, 10, spawn column
START_ROW, 12, spawn row
X_W, 10, o_Frog_X width
Y_W, 9, o_Frog_Y width
SCORE_W, 4, score width
SCORE_INI, 1, score loaded in IDLE
LIVES_INI, 3, lives loaded in IDLE (1..15)
REPEAT_DELAY, 3125000, hold cycles before first auto-repeat; 0 disables repeat
REPEAT_PERIOD, 1562500, cycles between auto-repeats (>=1)
RESPAWN_CYCLES, 25000000, cycles spent in RESPAWN

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  synchronous reset, active-high
i_Frog_Up  in  1  up request, level
i_Frog_Dn  in  1  down request
i_Frog_Lt  in  1  left request
i_Frog_Rt  in  1  right request
i_Has_Collided  in  1  car hit, level
i_Game_Active  in  1  game running
o_Frog_X  out  X_W  frog left pixel = col*TILE_SIZE
o_Frog_Y  out  Y_W  frog top pixel = row*TILE_SIZE
o_Score  out  SCORE_W  current level/score
o_Lives  out  4  lives remaining
o_Level_Up  out  1  1-cycle pulse on goal reached
o_Move  out  1  1-cycle pulse on every accepted step
o_Respawning  out  1  high while in RESPAWN
o_Game_Over  out  1  high while in GAME_OVER

Behaviour:
- Reset: state IDLE; col=START_COL, row=START_ROW; o_Score=SCORE_INI; o_Lives=LIVES_INI; all pulses and flags 0; repeat and respawn counters 0.
- All outputs are registered. Position outputs follow col/row with no extra latency: a step updates X/Y on the same edge it is accepted.
- States:
  - IDLE: hold spawn position, SCORE_INI and LIVES_INI. i_Game_Active=1 -> PLAY.
  - PLAY: movement enabled.
    - i_Has_Collided=1 -> lives-1 and position to spawn. Next state is GAME_OVER if the new lives value is 0, else RESPAWN.
    - Collision beats any move in the same cycle.
  - RESPAWN: position held at spawn; direction inputs and collision ignored; counter runs RESPAWN_CYCLES cycles, then -> PLAY. Repeat tracking is cleared on exit, so a held key needs release/repress or a fresh edge.
  - GAME_OVER: position at spawn; inputs ignored. i_Game_Active=0 -> IDLE.
  - i_Game_Active=0 in any state -> IDLE next edge. Score and lives reload in IDLE.
- Direction validity: exactly one of the four inputs high (one-hot). Anything else means no step and the repeat tracking is cleared.
- Step acceptance in PLAY:
  - Press edge: a valid direction that differs from last cycle's valid direction, or follows none, steps immediately and clears the hold counter.
  - Hold, first repeat: same direction held with REPEAT_DELAY>0 steps when the hold counter reaches REPEAT_DELAY.
  - Hold, later repeats: one step every REPEAT_PERIOD cycles after that.
- Bounds:
  - Down blocked at row GRID_H-1.
  - Left blocked at col 0.
  - Right blocked at col GRID_W-1.
  - A blocked step produces no o_Move, but the repeat timing still advances.
- Goal: Up at row 0 is not blocked.
  - Position returns to spawn, score+1 (saturates at 2^SCORE_W-1), o_Level_Up=1 for one cycle, o_Move=1, and lives are unchanged.
  - State stays PLAY and repeat tracking is cleared.
- Width: col*TILE_SIZE and row*TILE_SIZE must fit X_W/Y_W. Pixel outputs come from a registered multiply or a shift when TILE_SIZE is a power of two.
- Reset mid-RESPAWN or mid-repeat restores reset values on the next edge; no pending step survives.

Test Plan:
Parameters for all scenarios: TILE_SIZE=32, GRID_W=20, GRID_H=15, START 10/12, REPEAT_DELAY=4, REPEAT_PERIOD=2, RESPAWN_CYCLES=3, LIVES_INI=3.
1. Reset, then Game_Active=1 and a 1-cycle Rt pulse -> X 320->352 on the accept edge, o_Move=1 for one cycle, Y=384.
2. Hold Lt for 10 cycles -> steps at cycles 0, 4, 6, 8: X 320->288->256->224->192. Up+Lt together -> no step.
3. Press Up 12 times, then once more -> Y reaches 0; on the 13th step Score 1->2, o_Level_Up pulse, X/Y back to 320/384, Lives=3.
4. Collision in PLAY -> Lives 3->2, o_Respawning high 3 cycles, Rt ignored during it, and the Rt step is accepted once PLAY resumes. Collision in the same cycle as Dn -> respawn, no step.
5. Three collisions -> Lives 0, o_Game_Over=1, inputs ignored. Game_Active=0 -> IDLE with Score=1, Lives=3. Hold Dn at row 14 -> no o_Move and Y stays 448.
6. Assert i_Rst during RESPAWN and during held repeat -> all outputs at reset values on the next edge, and no spurious o_Move after release.
